// File: rtl/fifo_umbral_pkg.sv
// fifo_pkg: shared constants and helpers for the per-virtual-channel FIFOs.
//   FIFO_DATA_W_DEF / FIFO_DEPTH_DEF : default payload width and depth
//   FIFO_NUM_CHANNELS                : number of virtual channels in the datapath
//   fifo_cnt_w()                     : occupancy/threshold width for a given depth
//   fifo_op_e                        : accepted-operation classification per cycle
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W_DEF   = 6;
    localparam int unsigned FIFO_DEPTH_DEF    = 8;
    localparam int unsigned FIFO_NUM_CHANNELS = 5;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the address.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Encoded as {push accepted, pop accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_umbral_if.sv
// fifo_umbral_if: handshake/data bundle between a FIFO producer/consumer and fifo_umbral.
//   master : drives push, data_in, pop, umbral_af, umbral_ae; observes data and flags
//   slave  : the FIFO side (fifo_umbral)
interface fifo_umbral_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W_DEF,
    parameter int unsigned CNT_W  = fifo_cnt_w(FIFO_DEPTH_DEF)
);
    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [CNT_W-1:0]  umbral_af;
    logic [CNT_W-1:0]  umbral_ae;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              fifo_empty;
    logic              fifo_full;
    logic              almost_full;
    logic              almost_empty;
    logic              fifo_error;

    modport master (
        output push, data_in, pop, umbral_af, umbral_ae,
        input  data_out, valid_out, fifo_empty, fifo_full,
               almost_full, almost_empty, fifo_error
    );

    modport slave (
        input  push, data_in, pop, umbral_af, umbral_ae,
        output data_out, valid_out, fifo_empty, fifo_full,
               almost_full, almost_empty, fifo_error
    );
endinterface

// File: rtl/fifo_umbral_mem.sv
// fifo_mem: DEPTH x DATA_W register array, one synchronous write port and one
// synchronous read port whose output is registered.
//   clk, rst       : clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port; rdata updates the edge after re, holds otherwise
// Storage itself is not reset. A read and a write to the same address on the
// same edge returns the old contents.
module fifo_mem #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_umbral.sv
// fifo_umbral: single-clock FIFO with programmable almost-full/almost-empty
// thresholds and an overflow/underflow error flag, one per virtual channel.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : fifo_umbral_if.slave (push/data_in/pop/thresholds in;
//           data_out/valid_out/flags out)
// Build option: define FIFO_STICKY_ERR_EN to make fifo_error sticky until
// reset; otherwise it is a one-cycle pulse following the offending request.
// All flags are registered from the next-state occupancy so they line up with
// the count they describe.
module fifo_umbral
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W_DEF,
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbral_if.slave  bus
);

    localparam int unsigned CNT_W  = fifo_cnt_w(DEPTH);
    localparam int unsigned ADDR_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              valid_q,  valid_d;
    logic              empty_q,  empty_d;
    logic              full_q,   full_d;
    logic              af_q,     af_d;
    logic              ae_q,     ae_d;
    logic              err_q,    err_d;

    logic              is_full;
    logic              is_empty;
    logic              push_ok;
    logic              pop_ok;
    logic              bad_req;
    fifo_op_e          op;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        is_full  = (count_q == CNT_FULL);
        is_empty = (count_q == '0);

        // A pop on a full FIFO frees the slot the concurrent push needs, so
        // push acceptance depends on pop acceptance, not the reverse.
        pop_ok  = bus.pop && !is_empty;
        push_ok = bus.push && (!is_full || pop_ok);
        bad_req = (bus.push && !push_ok) || (bus.pop && !pop_ok);
        op      = fifo_op_e'({push_ok, pop_ok});

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case (op)
            OP_PUSH: count_d = count_q + CNT_W'(1);
            OP_POP:  count_d = count_q - CNT_W'(1);
            OP_BOTH: count_d = count_q;
            OP_IDLE: count_d = count_q;
            default: count_d = count_q;
        endcase

        valid_d = pop_ok;
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
        // count_d never exceeds DEPTH, so a threshold above DEPTH never fires.
        af_d    = (count_d >= bus.umbral_af);
        ae_d    = (count_d <= bus.umbral_ae);

`ifdef FIFO_STICKY_ERR_EN
        err_d = err_q || bad_req;
`else
        err_d = bad_req;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            err_q    <= err_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (reset),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .re    (pop_ok),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign bus.data_out     = rdata;
    assign bus.valid_out    = valid_q;
    assign bus.fifo_empty   = empty_q;
    assign bus.fifo_full    = full_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.fifo_error   = err_q;

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Single-clock synchronous FIFO with programmable almost-full/almost-empty thresholds and an error flag.
- One instance per virtual channel, five in the datapath.
- Sits directly upstream of the flow-control FSM and feeds it FIFO_empty, FIFO_error, almost_full and almost_empty.
- Takes its threshold values from the FSM's registered out_almost_full/out_almost_empty outputs.

Parameters:
- DATA_W, 6, payload width in bits.
- DEPTH, 8, number of entries; power of two, minimum 4.
- CNT_W, $clog2(DEPTH)+1, occupancy and threshold width; derived, do not override.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write request.
- data_in  input  DATA_W  write data, sampled when push=1.
- pop  input  1  read request.
- umbral_af  input  CNT_W  almost-full threshold.
- umbral_ae  input  CNT_W  almost-empty threshold.
- data_out  output  DATA_W  read data, registered.
- valid_out  output  1  data_out is valid this cycle.
- fifo_empty  output  1  occupancy == 0.
- fifo_full  output  1  occupancy == DEPTH.
- almost_full  output  1  occupancy >= umbral_af.
- almost_empty  output  1  occupancy <= umbral_ae.
- fifo_error  output  1  overflow or underflow flag.

Behaviour:
Reset
- Asserting reset clears: write/read pointers, count, data_out, valid_out, fifo_full, almost_full and fifo_error.
- During reset, fifo_empty=1 and almost_empty=1 regardless of thresholds.
- Reset mid-operation discards all contents immediately. Storage array contents are don't-care.

Write
- push=1 and not full: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
- Pointers are ADDR_W = CNT_W-1 bits and wrap naturally.

Read
- pop=1 and not empty: data_out <= mem[rd_ptr]; valid_out <= 1 on the next edge. Latency is 1 cycle from pop to data.
- Otherwise valid_out <= 0 and data_out holds its last value.

Count (CNT_W bits)
- Push only: +1. Pop only: -1. Both accepted: unchanged.

Simultaneous push and pop
- When full: both are accepted, count stays DEPTH, no error.
- When empty: pop is rejected (underflow), push is accepted, count becomes 1, fifo_error sets.

Overflow
- push while full without pop: write dropped, pointers unchanged, fifo_error sets.

Underflow
- pop while empty: no read, valid_out=0, fifo_error sets.

Flags
- All flags are registered and derived from the next-state count, so each is valid in the same cycle as the count it describes.
- Thresholds are compared combinationally against next count, then registered.
- A threshold change takes effect on the following edge.
- umbral_af > DEPTH means almost_full is never asserted.
- umbral_ae = 0 means almost_empty equals fifo_empty.

Optional Feature:
- Macro FIFO_STICKY_ERR_EN.
- Defined: fifo_error is sticky, set on any overflow/underflow and cleared only by reset. The FSM samples it at leisure.
- Undefined: fifo_error is a one-cycle pulse, asserted the cycle after the offending request and low otherwise.
- Data and pointer behaviour is identical in both builds.

Decomposition:
- Package fifo_pkg holds: default DATA_W/DEPTH constants, the CNT_W derivation function, and a localparam for the number of channels (5) shared with the FSM and the probador.
- One natural sub-module, fifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one synchronous read port (read data registered), no reset on storage.
- Pointer, count and flag logic stays in fifo_umbral.

Test Plan:
1. Reset, then umbral_af=6, umbral_ae=2, then push 0x01..0x06 on consecutive cycles. Required response:
   - almost_empty drops after the 3rd push.
   - almost_full rises after the 6th push.
   - fifo_full stays 0 and fifo_error stays 0.
2. Fill to 8, then push 0x3F one more cycle. Required response:
   - fifo_error=1 (sticky build) or a one-cycle pulse (non-sticky).
   - count stays 8.
   - Draining 8 pops returns 0x01..0x08 in order, each one cycle after its pop.
3. From empty, pop once. Required response:
   - valid_out stays 0.
   - fifo_error asserts.
   - fifo_empty stays 1.
4. Full FIFO, push 0x2A and pop in the same cycle. Required response:
   - data_out = oldest entry next cycle.
   - fifo_full stays 1, no error.
   - 0x2A is read out last.
5. Wrap-around: 20 cycles of alternating push/pop with incrementing data, then steady push+pop. Required response:
   - Output sequence matches input with no loss.
   - Pointers wrap past 7 correctly.
6. With 5 entries, assert reset for one half-cycle mid-stream. Required response:
   - fifo_empty=1, almost_empty=1 and valid_out=0 immediately.
   - Subsequent pops flag underflow.
